alu_pipe: RTL

Parametrised, pipelined N-bit ALU that generalises the team's 4-bit combinational AND unit to eight operations with status flags, an internal accumulator and a valid/ready handshake on both sides. It sits between the operand source (register file / test sequencer) and the result sink. It accepts one operation per cycle and returns results in order after two cycles.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_core.sv | 58 +++++
 rtl/alu_pipe.sv | 96 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes and status flag layout.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOT = 3'b011,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  localparam int FLAG_W = 4;

  // Flag vector is {negative, zero, carry, overflow}
  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/alu_core.sv
// Purely combinational N-bit ALU: maps (op, x, y) to result and status flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  op_e               op,
  input  logic [N-1:0]      x,
  input  logic [N-1:0]      y,
  output logic [N-1:0]      z,
  output logic [FLAG_W-1:0] flags
);

  logic [N:0] sum;
  logic [N:0] diff;
  logic       carry;
  logic       ovf;

  // SUB carry is the inverted borrow, so it reads 1 when x >= y unsigned
  always_comb begin
    sum   = {1'b0, x} + {1'b0, y};
    diff  = {1'b0, x} - {1'b0, y};
    z     = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      OP_AND: z = x & y;
      OP_OR:  z = x | y;
      OP_XOR: z = x ^ y;
      OP_NOT: z = ~x;
      OP_ADD: begin
        z     = sum[N-1:0];
        carry = sum[N];
        ovf   = (x[N-1] == y[N-1]) && (sum[N-1] != x[N-1]);
      end
      OP_SUB: begin
        z     = diff[N-1:0];
        carry = ~diff[N];
        ovf   = (x[N-1] != y[N-1]) && (diff[N-1] != x[N-1]);
      end
      OP_SHL: begin
        z     = {x[N-2:0], 1'b0};
        carry = x[N-1];
      end
      OP_SHR: begin
        z     = {1'b0, x[N-1:1]};
        carry = x[0];
      end
      default: z = '0;
    endcase
    flags        = '0;
    flags[FLG_N] = z[N-1];
    flags[FLG_Z] = (z == '0);
    flags[FLG_C] = carry;
    flags[FLG_V] = ovf;
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with accumulator and valid/ready handshakes on both sides.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [N-1:0]      in_x,
  input  logic [N-1:0]      in_y,
  input  logic              in_acc_src,
  input  logic              in_acc_we,
  input  logic              acc_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_z,
  output logic [FLAG_W-1:0] out_flags,
  output logic [N-1:0]      acc
);

  logic              s1_valid;
  op_e               s1_op;
  logic [N-1:0]      s1_x;
  logic [N-1:0]      s1_y;
  logic              s1_acc_src;
  logic              s1_acc_we;
  logic              s2_adv;
  logic              s1_adv;
  logic [N-1:0]      core_x;
  logic [N-1:0]      core_z;
  logic [FLAG_W-1:0] core_flags;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // X is resolved at the S1->S2 edge so a preceding accumulate is already visible
  assign core_x = s1_acc_src ? acc : s1_x;

  alu_core #(.N(N)) u_core (
    .op    (s1_op),
    .x     (core_x),
    .y     (s1_y),
    .z     (core_z),
    .flags (core_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_op      <= OP_AND;
      s1_x       <= '0;
      s1_y       <= '0;
      s1_acc_src <= 1'b0;
      s1_acc_we  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op      <= op_e'(in_op);
        s1_x       <= in_x;
        s1_y       <= in_y;
        s1_acc_src <= in_acc_src;
        s1_acc_we  <= in_acc_we;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_z     <= '0;
      out_flags <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_z     <= core_z;
        out_flags <= core_flags;
      end
    end
  end

  // Clear takes priority over a simultaneous write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (s1_valid && s2_adv && s1_acc_we) begin
      acc <= core_z;
    end
  end

endmodule
